// File: rtl/aes_encrypt_round_ctrl.sv
// Round sequencer for the iterative AES encryption datapath: steps the round-key
// index, drives the state-register mux/write-enable and hands off the ciphertext.
// IDX_W must satisfy 2**IDX_W > NUM_ROUNDS.
module aes_encrypt_round_ctrl #(
  parameter int unsigned NUM_ROUNDS = 14,
  parameter int unsigned IDX_W      = 4
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             key_ready,
  input  logic             flush,
  output logic [IDX_W-1:0] round_key_idx,
  output logic [1:0]       state_sel,
  output logic             state_we,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam logic [IDX_W-1:0] LAST_MID_IDX = IDX_W'(NUM_ROUNDS - 1);
  localparam logic [IDX_W-1:0] FINAL_IDX    = IDX_W'(NUM_ROUNDS);
  localparam logic [1:0]       SEL_INIT     = 2'b00;
  localparam logic [1:0]       SEL_MID      = 2'b01;
  localparam logic [1:0]       SEL_FINAL    = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_ROUND,
    S_FINAL,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] round_cnt_q, round_cnt_d;
  logic             idle_q, idle_d;
  logic             we_q, we_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [1:0]       sel_q, sel_d;
  logic             busy_q, busy_d;
  logic             out_valid_q, out_valid_d;

  // key_ready gates the registered enables so a stall cycle never writes or accepts
  assign in_ready      = idle_q & key_ready;
  assign state_we      = we_q & key_ready;
  assign round_key_idx = idx_q;
  assign state_sel     = sel_q;
  assign busy          = busy_q;
  assign out_valid     = out_valid_q;

  // State, round counter and output registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= S_IDLE;
      round_cnt_q <= '0;
      idle_q      <= 1'b0;
      we_q        <= 1'b0;
      idx_q       <= '0;
      sel_q       <= SEL_INIT;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      round_cnt_q <= round_cnt_d;
      idle_q      <= idle_d;
      we_q        <= we_d;
      idx_q       <= idx_d;
      sel_q       <= sel_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next state plus output values for the cycle that state will occupy
  always_comb begin
    state_d     = state_q;
    round_cnt_d = round_cnt_q;
    idle_d      = 1'b0;
    we_d        = 1'b0;
    idx_d       = '0;
    sel_d       = SEL_INIT;
    busy_d      = 1'b0;
    out_valid_d = 1'b0;

    if (flush && (state_q != S_IDLE)) begin
      state_d     = S_IDLE;
      round_cnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid && in_ready) state_d = S_INIT;
        end
        S_INIT: begin
          if (key_ready) begin
            state_d     = S_ROUND;
            round_cnt_d = IDX_W'(1);
          end
        end
        S_ROUND: begin
          if (key_ready) begin
            if (round_cnt_q == LAST_MID_IDX) state_d = S_FINAL;
            else round_cnt_d = round_cnt_q + IDX_W'(1);
          end
        end
        S_FINAL: begin
          if (key_ready) state_d = S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            state_d     = S_IDLE;
            round_cnt_d = '0;
          end
        end
        default: begin
          state_d     = S_IDLE;
          round_cnt_d = '0;
        end
      endcase
    end

    case (state_d)
      S_IDLE: idle_d = 1'b1;
      S_INIT: begin
        we_d   = 1'b1;
        busy_d = 1'b1;
      end
      S_ROUND: begin
        we_d   = 1'b1;
        sel_d  = SEL_MID;
        idx_d  = round_cnt_d;
        busy_d = 1'b1;
      end
      S_FINAL: begin
        sel_d  = SEL_FINAL;
        idx_d  = FINAL_IDX;
        busy_d = 1'b1;
      end
      S_DONE: begin
        idx_d       = FINAL_IDX;
        busy_d      = 1'b1;
        out_valid_d = 1'b1;
      end
      default: idle_d = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_aes_encrypt_round_ctrl.sv
// Bench for aes_encrypt_round_ctrl: AES-256 and AES-128 instances driving a small
// stand-in datapath, checked cycle by cycle against a round-step reference model.
module tb_aes_encrypt_round_ctrl;

  logic sys_clk = 1'b0;
  logic sys_rst_n;
  logic in_valid, key_ready, flush, out_ready, use10;

  logic       in_ready_a, state_we_a, busy_a, out_valid_a;
  logic [3:0] idx_a;
  logic [1:0] sel_a;
  logic       in_ready_b, state_we_b, busy_b, out_valid_b;
  logic [3:0] idx_b;
  logic [1:0] sel_b;

  logic       o_in_ready, o_we, o_busy, o_ov;
  logic [3:0] o_idx;
  logic [1:0] o_sel;

  logic [31:0] pt, st, fin;
  logic [31:0] key [16];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 sys_clk = ~sys_clk;

  aes_encrypt_round_ctrl #(.NUM_ROUNDS(14), .IDX_W(4)) u_dut_256 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .in_valid(in_valid & ~use10), .in_ready(in_ready_a),
    .key_ready(key_ready), .flush(flush),
    .round_key_idx(idx_a), .state_sel(sel_a), .state_we(state_we_a),
    .busy(busy_a), .out_valid(out_valid_a), .out_ready(out_ready)
  );

  aes_encrypt_round_ctrl #(.NUM_ROUNDS(10), .IDX_W(4)) u_dut_128 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .in_valid(in_valid & use10), .in_ready(in_ready_b),
    .key_ready(key_ready), .flush(flush),
    .round_key_idx(idx_b), .state_sel(sel_b), .state_we(state_we_b),
    .busy(busy_b), .out_valid(out_valid_b), .out_ready(out_ready)
  );

  always_comb begin
    o_in_ready = use10 ? in_ready_b  : in_ready_a;
    o_we       = use10 ? state_we_b  : state_we_a;
    o_busy     = use10 ? busy_b      : busy_a;
    o_ov       = use10 ? out_valid_b : out_valid_a;
    o_idx      = use10 ? idx_b       : idx_a;
    o_sel      = use10 ? sel_b       : sel_a;
  end

  function automatic logic [31:0] mix(input logic [31:0] s, input logic [31:0] k);
    return {s[26:0], s[31:27]} ^ (s + k) ^ 32'h9e3779b9;
  endfunction

  function automatic logic [31:0] fmix(input logic [31:0] s, input logic [31:0] k);
    return {s[15:0], s[31:16]} ^ k;
  endfunction

  // Stand-in round datapath steered by the selected controller
  always_ff @(posedge sys_clk) begin
    if (o_we) st <= (o_sel == 2'b00) ? (pt ^ key[o_idx]) : mix(st, key[o_idx]);
    if (o_sel == 2'b10) fin <= fmix(st, key[o_idx]);
  end

  function automatic logic [31:0] ref_cipher(input int nr);
    logic [31:0] s;
    s = pt ^ key[0];
    for (int r = 1; r < nr; r++) s = mix(s, key[r]);
    return fmix(s, key[nr]);
  endfunction

  // One block from accept to hand-off (or flush). Called at a falling edge.
  // flush_step: -1 none, -2 flush only during the IDLE accept cycle, else the step to abort in.
  task automatic run_block(input bit b10, input int stall_step, input int stall_len,
                           input int bp_len, input int flush_step, input string tag);
    int nr, step, stalled, done_cyc, first_ov, exp_lat;
    bit kr, fl, orr, finished;
    logic [9:0] got, exp;
    nr = b10 ? 10 : 14;
    use10 = b10;
    pt = $urandom;
    for (int i = 0; i < 16; i++) key[i] = $urandom;
    in_valid = 1'b1; key_ready = 1'b1; out_ready = 1'b0;
    flush = (flush_step == -2);
    #1;
    n_checks++;
    if ({o_busy, o_ov, o_in_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL %s accept: busy/out_valid/in_ready=%b expected 001", tag, {o_busy, o_ov, o_in_ready});
    end
    @(negedge sys_clk);
    in_valid = 1'b0;
    step = 0; stalled = 0; done_cyc = 0; first_ov = -1; finished = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      kr = !(step == stall_step && stalled < stall_len);
      if (!kr) stalled++;
      fl  = (step == flush_step);
      orr = (step > nr) && (done_cyc >= bp_len);
      key_ready = kr; flush = fl; out_ready = orr;
      #1;
      if (step <= nr)
        exp = {4'(step), (step == 0) ? 2'b00 : ((step < nr) ? 2'b01 : 2'b10),
               kr && (step < nr), 1'b1, 1'b0, 1'b0};
      else
        exp = {4'(nr), 2'b00, 1'b0, 1'b1, 1'b1, 1'b0};
      got = {o_idx, o_sel, o_we, o_busy, o_ov, o_in_ready};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL %s cycle %0d idx/sel/we/busy/ov/in_ready: got %b expected %b", tag, c, got, exp);
      end
      if (o_ov === 1'b1 && first_ov < 0) first_ov = c;
      if (step > nr && done_cyc == 0) begin
        n_checks++;
        if (fin !== ref_cipher(nr)) begin
          n_fail++;
          $display("FAIL %s ciphertext: got %h expected %h", tag, fin, ref_cipher(nr));
        end
      end
      if (fl) finished = 1'b1;
      else if (step <= nr) begin
        if (kr) step++;
      end else if (orr) finished = 1'b1;
      else done_cyc++;
      @(negedge sys_clk);
      if (finished) break;
    end
    flush = 1'b0; out_ready = 1'b0; key_ready = 1'b1;
    if (!finished) begin
      n_checks++; n_fail++;
      $display("FAIL %s timeout: block did not complete within 200 cycles", tag);
    end else if (flush_step >= 0 && flush_step <= nr) begin
      n_checks++;
      if (first_ov != -1) begin
        n_fail++;
        $display("FAIL %s flush: out_valid rose at cycle %0d expected never", tag, first_ov);
      end
    end else begin
      exp_lat = nr + 2 + ((stall_step >= 0 && stall_step <= nr) ? stall_len : 0);
      n_checks++;
      if (first_ov != exp_lat) begin
        n_fail++;
        $display("FAIL %s latency: out_valid first at cycle %0d expected %0d", tag, first_ov, exp_lat);
      end
    end
  endtask

  task automatic check_idle(input string tag);
    #1;
    n_checks++;
    if ({o_busy, o_ov, o_we, o_in_ready} !== {3'b000, key_ready}) begin
      n_fail++;
      $display("FAIL %s idle: busy/ov/we/in_ready=%b expected %b", tag,
               {o_busy, o_ov, o_we, o_in_ready}, {3'b000, key_ready});
    end
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0; in_valid = 1'b0; key_ready = 1'b1; flush = 1'b0;
    out_ready = 1'b0; use10 = 1'b0;
    #12;
    n_checks++;
    if ({in_ready_a, state_we_a, busy_a, out_valid_a, idx_a, sel_a,
         in_ready_b, state_we_b, busy_b, out_valid_b, idx_b, sel_b} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset: outputs not all zero (a idx=%h sel=%b in_ready=%b)", idx_a, sel_a, in_ready_a);
    end
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    check_idle("reset_release");
  endtask

  task automatic test_flush_idle();
    key_ready = 1'b1; flush = 1'b1; in_valid = 1'b0;
    @(negedge sys_clk);
    flush = 1'b0;
    check_idle("flush_in_idle");
    @(negedge sys_clk);
    run_block(1'b0, -1, 0, 0, -2, "accept_with_flush");
  endtask

  task automatic test_async_reset();
    bit hit;
    use10 = 1'b0; pt = $urandom;
    for (int i = 0; i < 16; i++) key[i] = $urandom;
    in_valid = 1'b1; key_ready = 1'b1; flush = 1'b0; out_ready = 1'b0;
    @(negedge sys_clk);
    in_valid = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 30; c++) begin
      #1;
      if (o_idx === 4'd9) begin hit = 1'b1; break; end
      @(negedge sys_clk);
    end
    n_checks++;
    if (!hit) begin
      n_fail++;
      $display("FAIL async_reset: round_key_idx never reached 9, got %h", o_idx);
    end
    #1 sys_rst_n = 1'b0;
    #1;
    n_checks++;
    if ({in_ready_a, state_we_a, busy_a, out_valid_a, idx_a, sel_a} !== 10'h0) begin
      n_fail++;
      $display("FAIL async_reset: outputs %b expected all zero",
               {in_ready_a, state_we_a, busy_a, out_valid_a, idx_a, sel_a});
    end
    @(negedge sys_clk);
    sys_rst_n = 1'b1; key_ready = 1'b0;
    @(negedge sys_clk);
    check_idle("post_reset_key_low");
    key_ready = 1'b1;
    check_idle("post_reset_key_high");
    run_block(1'b0, -1, 0, 0, -1, "cold_after_reset");
  endtask

  task automatic test_random(input int n);
    int nr, ss, sl, bp, fs;
    bit b10;
    for (int i = 0; i < n; i++) begin
      b10 = 1'($urandom_range(0, 1));
      nr  = b10 ? 10 : 14;
      ss  = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, nr));
      sl  = int'($urandom_range(1, 4));
      bp  = int'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0:       fs = int'($urandom_range(0, nr + 1));
        1:       fs = -2;
        default: fs = -1;
      endcase
      run_block(b10, ss, sl, bp, fs, "random");
    end
  endtask

  initial begin
    test_reset();
    run_block(1'b0, -1, 0, 0, -1, "nominal_256");
    run_block(1'b0, -1, 0, 5, -1, "backpressure");
    run_block(1'b0, 7, 3, 0, -1, "stall_idx7");
    run_block(1'b0, 0, 2, 0, -1, "stall_init");
    run_block(1'b0, 14, 2, 0, -1, "stall_final");
    run_block(1'b0, -1, 0, 0, 5, "flush_round5");
    run_block(1'b0, -1, 0, 0, -1, "after_flush");
    run_block(1'b0, -1, 0, 3, 15, "flush_in_done");
    test_flush_idle();
    test_async_reset();
    run_block(1'b1, -1, 0, 0, -1, "nominal_128");
    run_block(1'b1, 5, 2, 1, -1, "stall_128");
    run_block(1'b0, -1, 0, 0, -1, "back_to_back_a");
    run_block(1'b0, -1, 0, 0, -1, "back_to_back_b");
    test_random(24);
    check_idle("final");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
